// File: rtl/irq_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : irq_controller                                                  |
// | Purpose  : Edge-captured, masked, fixed-priority interrupt controller.     |
// |            Sequences a single-level interrupt entry (vector + return push) |
// |            and releases the in-service line on reti.                       |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module irq_controller #(
  parameter int              NIRQ       = 4,
  parameter int              PC_W       = 10,
  parameter logic [PC_W-1:0] VEC_BASE   = PC_W'(1000),
  parameter int              VEC_STRIDE = 4,
  localparam int             ID_W       = (NIRQ > 1) ? $clog2(NIRQ) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NIRQ-1:0] irq,
  input  logic            mask_we,
  input  logic [NIRQ-1:0] mask_wd,
  input  logic [PC_W-1:0] pc_ret,
  input  logic            reti,
  input  logic            stack_full,
  output logic            irq_take,
  output logic [PC_W-1:0] vector,
  output logic            stack_push,
  output logic [PC_W-1:0] push_data,
  output logic            stack_pop,
  output logic            in_service,
  output logic [ID_W-1:0] active_id,
  output logic [NIRQ-1:0] pending,
  output logic            err_reti
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    TAKE    = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t          state_q;
  logic            irq_take_q;
  logic            in_service_q;
  logic [ID_W-1:0] active_id_q;
  logic [PC_W-1:0] vector_q;
  logic            err_q;
  logic [NIRQ-1:0] irq_prev_q;
  logic [NIRQ-1:0] mask_q;
  logic [NIRQ-1:0] pending_q;
  logic [NIRQ-1:0] pending_d;

  logic [NIRQ-1:0] w_edges;
  logic [NIRQ-1:0] w_eligible;
  logic [NIRQ-1:0] w_take_clr;
  logic [ID_W-1:0] w_win_id;
  logic [PC_W-1:0] w_win_vec;

  assign w_edges    = irq & ~irq_prev_q;
  assign w_eligible = pending_q & mask_q;

  // Lowest eligible index wins: scan downward so the last hit is the lowest.
  always_comb begin
    w_win_id = '0;
    for (int i = NIRQ - 1; i >= 0; i--) begin
      if (w_eligible[i]) begin
        w_win_id = ID_W'(i);
      end
    end
  end

  // Vector arithmetic is done in PC_W bits so it wraps naturally.
  assign w_win_vec = VEC_BASE + (PC_W'(w_win_id) * PC_W'(VEC_STRIDE));

  // Pending clears for the taken line when TAKE closes; a fresh edge on that
  // same line in that cycle must survive, hence the OR after the clear.
  always_comb begin
    w_take_clr = '0;
    if (state_q == TAKE) begin
      w_take_clr = NIRQ'(1) << active_id_q;
    end
    pending_d = (pending_q & ~w_take_clr) | w_edges;
  end

  // Edge-detect history, mask register and pending request bits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_prev_q <= '0;
      mask_q     <= '0;
      pending_q  <= '0;
    end else begin
      irq_prev_q <= irq;
      pending_q  <= pending_d;
      if (mask_we) begin
        mask_q <= mask_wd;
      end
    end
  end

  // Entry sequencer with registered take/service outputs and sticky reti error.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      irq_take_q   <= 1'b0;
      in_service_q <= 1'b0;
      active_id_q  <= '0;
      vector_q     <= '0;
      err_q        <= 1'b0;
    end else begin
      if (reti && (state_q != SERVICE)) begin
        err_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if ((|w_eligible) && !stack_full) begin
            state_q     <= TAKE;
            irq_take_q  <= 1'b1;
            active_id_q <= w_win_id;
            vector_q    <= w_win_vec;
          end
        end
        TAKE: begin
          state_q      <= SERVICE;
          irq_take_q   <= 1'b0;
          in_service_q <= 1'b1;
        end
        SERVICE: begin
          if (reti) begin
            state_q      <= IDLE;
            in_service_q <= 1'b0;
          end
        end
        default: begin
          state_q      <= IDLE;
          irq_take_q   <= 1'b0;
          in_service_q <= 1'b0;
        end
      endcase
    end
  end

  assign irq_take   = irq_take_q;
  assign stack_push = irq_take_q;
  assign vector     = vector_q;
  assign push_data  = irq_take_q ? pc_ret : '0;
  assign stack_pop  = (state_q == SERVICE) && reti;
  assign in_service = in_service_q;
  assign active_id  = active_id_q;
  assign pending    = pending_q;
  assign err_reti   = err_q;

endmodule
`default_nettype wire
